// File: rtl/dual_port_mem_arbiter_if.sv
// Bus bundle for dual_port_mem_arbiter: requester handshakes (A and B),
// memory port controls and read-data return. The "master" modport is the
// requester/memory side, "slave" is the arbiter itself.
interface dual_port_mem_arbiter_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_BANK   = 4
);
  localparam int BANK_W = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;

  logic                  i_req_valid_a;
  logic                  i_req_valid_b;
  logic                  o_req_ready_a;
  logic                  o_req_ready_b;
  logic                  i_req_we_a;
  logic                  i_req_we_b;
  logic [ADDR_WIDTH-1:0] i_req_addr_a;
  logic [ADDR_WIDTH-1:0] i_req_addr_b;
  logic [WIDTH-1:0]      i_req_wdata_a;
  logic [WIDTH-1:0]      i_req_wdata_b;

  logic                  o_mem_en_a;
  logic                  o_mem_en_b;
  logic                  o_mem_we_a;
  logic                  o_mem_we_b;
  logic [ADDR_WIDTH-1:0] o_mem_addr_a;
  logic [ADDR_WIDTH-1:0] o_mem_addr_b;
  logic [WIDTH-1:0]      o_mem_din_a;
  logic [WIDTH-1:0]      o_mem_din_b;
  logic [BANK_W-1:0]     o_mem_bank_a;
  logic [BANK_W-1:0]     o_mem_bank_b;
  logic [WIDTH-1:0]      i_mem_dout_a;
  logic [WIDTH-1:0]      i_mem_dout_b;

  logic                  o_rvalid_a;
  logic                  o_rvalid_b;
  logic [WIDTH-1:0]      o_rdata_a;
  logic [WIDTH-1:0]      o_rdata_b;
  logic                  o_idle;
  logic [15:0]           o_conflict_cnt;

  modport master (
    output i_req_valid_a, i_req_valid_b, i_req_we_a, i_req_we_b,
    output i_req_addr_a, i_req_addr_b, i_req_wdata_a, i_req_wdata_b,
    input  o_req_ready_a, o_req_ready_b,
    input  o_mem_en_a, o_mem_en_b, o_mem_we_a, o_mem_we_b,
    input  o_mem_addr_a, o_mem_addr_b, o_mem_din_a, o_mem_din_b,
    input  o_mem_bank_a, o_mem_bank_b,
    output i_mem_dout_a, i_mem_dout_b,
    input  o_rvalid_a, o_rvalid_b, o_rdata_a, o_rdata_b,
    input  o_idle, o_conflict_cnt
  );

  modport slave (
    input  i_req_valid_a, i_req_valid_b, i_req_we_a, i_req_we_b,
    input  i_req_addr_a, i_req_addr_b, i_req_wdata_a, i_req_wdata_b,
    output o_req_ready_a, o_req_ready_b,
    output o_mem_en_a, o_mem_en_b, o_mem_we_a, o_mem_we_b,
    output o_mem_addr_a, o_mem_addr_b, o_mem_din_a, o_mem_din_b,
    output o_mem_bank_a, o_mem_bank_b,
    input  i_mem_dout_a, i_mem_dout_b,
    output o_rvalid_a, o_rvalid_b, o_rdata_a, o_rdata_b,
    output o_idle, o_conflict_cnt
  );
endinterface

// File: rtl/dual_port_mem_arbiter.sv
// Request scheduler in front of a dual-port multi-bank memory.
// Two requesters (A, B) are granted combinationally; a same-address pair
// involving a write is resolved by a round-robin pointer that moves to the
// loser. Grants are issued to memory one cycle later on fixed ports, and
// reads come back with a valid strobe READ_LATENCY cycles after issue.
// Optional feature: define DPM_ARB_CONFLICT_CNT_EN to enable the saturating
// conflict counter; otherwise o_conflict_cnt is tied to zero.
module dual_port_mem_arbiter #(
  parameter int WIDTH        = 8,
  parameter int ADDR_WIDTH   = 5,
  parameter int NUM_BANK     = 4,
  parameter int READ_LATENCY = 2
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  dual_port_mem_arbiter_if.slave bus
);
  localparam int BANK_W = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;

  logic                    conflict;
  logic                    grant_a;
  logic                    grant_b;
  logic                    prio_b;

  logic                    mem_en_a;
  logic                    mem_en_b;
  logic                    mem_we_a;
  logic                    mem_we_b;
  logic [ADDR_WIDTH-1:0]   mem_addr_a;
  logic [ADDR_WIDTH-1:0]   mem_addr_b;
  logic [WIDTH-1:0]        mem_din_a;
  logic [WIDTH-1:0]        mem_din_b;
  logic [BANK_W-1:0]       mem_bank_a;
  logic [BANK_W-1:0]       mem_bank_b;

  logic [READ_LATENCY-1:0] rd_pipe_a;
  logic [READ_LATENCY-1:0] rd_pipe_b;
  logic [READ_LATENCY:0]   rd_next_a;
  logic [READ_LATENCY:0]   rd_next_b;
  logic                    rvalid_a;
  logic                    rvalid_b;

  // Hazard detection and grant: reads to the same address coexist, anything
  // involving a write goes to the priority holder only. Nothing is granted
  // while reset is asserted.
  always_comb begin
    conflict = i_rst_n & bus.i_req_valid_a & bus.i_req_valid_b &
               (bus.i_req_addr_a == bus.i_req_addr_b) &
               (bus.i_req_we_a | bus.i_req_we_b);
    grant_a  = i_rst_n & bus.i_req_valid_a & (~conflict | ~prio_b);
    grant_b  = i_rst_n & bus.i_req_valid_b & (~conflict | prio_b);
  end

  assign bus.o_req_ready_a = grant_a;
  assign bus.o_req_ready_b = grant_b;

  // Round-robin pointer: on a conflict the loser becomes the next priority holder.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prio_b <= 1'b0;
    end else if (conflict) begin
      prio_b <= ~prio_b;
    end
  end

  // Issue stage for port A: register the granted request; address and data hold when idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_en_a   <= 1'b0;
      mem_we_a   <= 1'b0;
      mem_addr_a <= '0;
      mem_din_a  <= '0;
      mem_bank_a <= '0;
    end else begin
      mem_en_a <= grant_a;
      if (grant_a) begin
        mem_we_a   <= bus.i_req_we_a;
        mem_addr_a <= bus.i_req_addr_a;
        mem_din_a  <= bus.i_req_wdata_a;
        mem_bank_a <= bus.i_req_addr_a[ADDR_WIDTH-1 -: BANK_W];
      end
    end
  end

  // Issue stage for port B: same behaviour as port A on its own memory port.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_en_b   <= 1'b0;
      mem_we_b   <= 1'b0;
      mem_addr_b <= '0;
      mem_din_b  <= '0;
      mem_bank_b <= '0;
    end else begin
      mem_en_b <= grant_b;
      if (grant_b) begin
        mem_we_b   <= bus.i_req_we_b;
        mem_addr_b <= bus.i_req_addr_b;
        mem_din_b  <= bus.i_req_wdata_b;
        mem_bank_b <= bus.i_req_addr_b[ADDR_WIDTH-1 -: BANK_W];
      end
    end
  end

  assign rd_next_a = {rd_pipe_a, mem_en_a & ~mem_we_a};
  assign rd_next_b = {rd_pipe_b, mem_en_b & ~mem_we_b};

  // Read tracking: each issued read travels READ_LATENCY stages to match memory latency.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_pipe_a <= '0;
      rd_pipe_b <= '0;
    end else begin
      rd_pipe_a <= rd_next_a[READ_LATENCY-1:0];
      rd_pipe_b <= rd_next_b[READ_LATENCY-1:0];
    end
  end

  assign rvalid_a = rd_pipe_a[READ_LATENCY-1];
  assign rvalid_b = rd_pipe_b[READ_LATENCY-1];

  assign bus.o_mem_en_a   = mem_en_a;
  assign bus.o_mem_en_b   = mem_en_b;
  assign bus.o_mem_we_a   = mem_we_a;
  assign bus.o_mem_we_b   = mem_we_b;
  assign bus.o_mem_addr_a = mem_addr_a;
  assign bus.o_mem_addr_b = mem_addr_b;
  assign bus.o_mem_din_a  = mem_din_a;
  assign bus.o_mem_din_b  = mem_din_b;
  assign bus.o_mem_bank_a = mem_bank_a;
  assign bus.o_mem_bank_b = mem_bank_b;

  assign bus.o_rvalid_a = rvalid_a;
  assign bus.o_rvalid_b = rvalid_b;
  assign bus.o_rdata_a  = rvalid_a ? bus.i_mem_dout_a : '0;
  assign bus.o_rdata_b  = rvalid_b ? bus.i_mem_dout_b : '0;

  assign bus.o_idle = ~mem_en_a & ~mem_en_b & ~(|rd_pipe_a) & ~(|rd_pipe_b);

`ifdef DPM_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;

  // Conflict counter: one per conflict cycle, sticking at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      conflict_cnt <= 16'h0000;
    end else if (conflict && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  assign bus.o_conflict_cnt = conflict_cnt;
`else
  assign bus.o_conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_dual_port_mem_arbiter.sv
// Self-checking bench for dual_port_mem_arbiter (READ_LATENCY = 2).
// A table of single-cycle request vectors with hand-computed grants, issue
// fields and read returns, plus directed sequences for reset, a single read
// and reset in the middle of in-flight reads.
module tb_dual_port_mem_arbiter;
  localparam int WIDTH = 8;
  localparam int AW    = 5;
  localparam int NB    = 4;
  localparam int RL    = 2;
  localparam int NVEC  = 18;

  typedef struct {
    logic       va;
    logic       vb;
    logic       wea;
    logic       web;
    logic [4:0] aa;
    logic [4:0] ab;
    logic [7:0] da;
    logic [7:0] db;
    logic       ra;
    logic       rb;
    int         cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dual_port_mem_arbiter_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .NUM_BANK(NB)) bus ();

  dual_port_mem_arbiter #(
    .WIDTH(WIDTH), .ADDR_WIDTH(AW), .NUM_BANK(NB), .READ_LATENCY(RL)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic va, input logic vb, input logic wea, input logic web,
                                input logic [4:0] aa, input logic [4:0] ab,
                                input logic [7:0] da, input logic [7:0] db);
    bus.i_req_valid_a = va;
    bus.i_req_valid_b = vb;
    bus.i_req_we_a    = wea;
    bus.i_req_we_b    = web;
    bus.i_req_addr_a  = aa;
    bus.i_req_addr_b  = ab;
    bus.i_req_wdata_a = da;
    bus.i_req_wdata_b = db;
  endtask

  function automatic int exp_cnt(input int n);
`ifdef DPM_ARB_CONFLICT_CNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  vec_t       vecs [NVEC];
  logic       rda [NVEC];
  logic       rdb [NVEC];
  logic [4:0] ea_addr, eb_addr;
  logic [7:0] ea_din, eb_din;
  logic       ea_we, eb_we;
  logic       exp_rv_a, exp_rv_b, exp_idle;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'h07, 5'h00, 8'h00, 8'h00, 1'b1, 1'b0, 0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 5'h1C, 5'h1C, 8'h11, 8'h22, 1'b1, 1'b0, 1};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 5'h1C, 5'h1C, 8'h11, 8'h22, 1'b0, 1'b1, 2};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'h03, 5'h03, 8'h00, 8'h00, 1'b1, 1'b1, 2};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 5'h0A, 5'h0A, 8'h33, 8'h00, 1'b1, 1'b0, 3};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 5'h0A, 5'h0A, 8'h33, 8'h00, 1'b0, 1'b1, 4};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 5'h10, 5'h11, 8'h44, 8'h55, 1'b1, 1'b1, 4};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 5'h00, 8'h00, 8'h00, 1'b0, 1'b0, 4};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'h00, 5'h1F, 8'h00, 8'h00, 1'b0, 1'b1, 4};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 5'h12, 5'h12, 8'h00, 8'h66, 1'b1, 1'b0, 5};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'h12, 5'h12, 8'h00, 8'h66, 1'b0, 1'b1, 6};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'h05, 5'h05, 8'h77, 8'h88, 1'b1, 1'b0, 7};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'h05, 5'h05, 8'h77, 8'h88, 1'b0, 1'b1, 8};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'h05, 5'h05, 8'h77, 8'h88, 1'b1, 1'b0, 9};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'h05, 5'h05, 8'h77, 8'h88, 1'b0, 1'b1, 10};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 5'h00, 8'h00, 8'h00, 1'b0, 1'b0, 10};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 5'h00, 8'h00, 8'h00, 1'b0, 1'b0, 10};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 5'h00, 8'h00, 8'h00, 1'b0, 1'b0, 10};

    rst_n = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 5'h00, 8'h00, 8'h00);
    bus.i_mem_dout_a = 8'h5A;
    bus.i_mem_dout_b = 8'hA5;

    // reset held with random requests: nothing granted or issued
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      apply_stimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     5'($urandom), 5'($urandom), 8'($urandom), 8'($urandom));
      #1;
      check_output("rst_ready_a", 32'(bus.o_req_ready_a), 32'd0);
      check_output("rst_ready_b", 32'(bus.o_req_ready_b), 32'd0);
      @(posedge clk);
      #1;
      check_output("rst_en_a", 32'(bus.o_mem_en_a), 32'd0);
      check_output("rst_en_b", 32'(bus.o_mem_en_b), 32'd0);
      check_output("rst_addr_a", 32'(bus.o_mem_addr_a), 32'd0);
      check_output("rst_rvalid_a", 32'(bus.o_rvalid_a), 32'd0);
      check_output("rst_idle", 32'(bus.o_idle), 32'd1);
      check_output("rst_cnt", 32'(bus.o_conflict_cnt), 32'd0);
    end
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 5'h00, 8'h00, 8'h00);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("rel_en_a", 32'(bus.o_mem_en_a), 32'd0);

    // single read on A, addr 07, memory returns 5A
    @(negedge clk);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'h07, 5'h00, 8'h00, 8'h00);
    #1;
    check_output("sr_ready_a", 32'(bus.o_req_ready_a), 32'd1);
    @(posedge clk);
    #1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'h07, 5'h00, 8'h00, 8'h00);
    check_output("sr_en_a", 32'(bus.o_mem_en_a), 32'd1);
    check_output("sr_we_a", 32'(bus.o_mem_we_a), 32'd0);
    check_output("sr_addr_a", 32'(bus.o_mem_addr_a), 32'h07);
    check_output("sr_bank_a", 32'(bus.o_mem_bank_a), 32'd0);
    check_output("sr_idle_busy", 32'(bus.o_idle), 32'd0);
    check_output("sr_rvalid_t1", 32'(bus.o_rvalid_a), 32'd0);
    @(posedge clk);
    #1;
    check_output("sr_rvalid_t2", 32'(bus.o_rvalid_a), 32'd0);
    check_output("sr_en_a_off", 32'(bus.o_mem_en_a), 32'd0);
    @(posedge clk);
    #1;
    check_output("sr_rvalid_t3", 32'(bus.o_rvalid_a), 32'd1);
    check_output("sr_rdata_t3", 32'(bus.o_rdata_a), 32'h5A);
    @(posedge clk);
    #1;
    check_output("sr_rvalid_t4", 32'(bus.o_rvalid_a), 32'd0);
    check_output("sr_rdata_t4", 32'(bus.o_rdata_a), 32'd0);
    check_output("sr_idle_end", 32'(bus.o_idle), 32'd1);

    // table-driven vectors
    bus.i_mem_dout_a = 8'hC3;
    bus.i_mem_dout_b = 8'h3C;
    ea_addr = 5'h07; ea_din = 8'h00; ea_we = 1'b0;
    eb_addr = 5'h00; eb_din = 8'h00; eb_we = 1'b0;
    for (int k = 0; k < NVEC; k++) begin
      @(negedge clk);
      apply_stimulus(vecs[k].va, vecs[k].vb, vecs[k].wea, vecs[k].web,
                     vecs[k].aa, vecs[k].ab, vecs[k].da, vecs[k].db);
      rda[k] = vecs[k].ra & ~vecs[k].wea;
      rdb[k] = vecs[k].rb & ~vecs[k].web;
      if (vecs[k].ra) begin ea_addr = vecs[k].aa; ea_din = vecs[k].da; ea_we = vecs[k].wea; end
      if (vecs[k].rb) begin eb_addr = vecs[k].ab; eb_din = vecs[k].db; eb_we = vecs[k].web; end
      #1;
      check_output($sformatf("v%0d_ready_a", k), 32'(bus.o_req_ready_a), 32'(vecs[k].ra));
      check_output($sformatf("v%0d_ready_b", k), 32'(bus.o_req_ready_b), 32'(vecs[k].rb));
      @(posedge clk);
      #1;
      exp_rv_a = (k >= 2) ? rda[k-2] : 1'b0;
      exp_rv_b = (k >= 2) ? rdb[k-2] : 1'b0;
      exp_idle = !(vecs[k].ra || vecs[k].rb);
      if (k >= 1) exp_idle = exp_idle && !rda[k-1] && !rdb[k-1];
      if (k >= 2) exp_idle = exp_idle && !rda[k-2] && !rdb[k-2];
      check_output($sformatf("v%0d_en_a", k), 32'(bus.o_mem_en_a), 32'(vecs[k].ra));
      check_output($sformatf("v%0d_en_b", k), 32'(bus.o_mem_en_b), 32'(vecs[k].rb));
      check_output($sformatf("v%0d_we_a", k), 32'(bus.o_mem_we_a), 32'(ea_we));
      check_output($sformatf("v%0d_we_b", k), 32'(bus.o_mem_we_b), 32'(eb_we));
      check_output($sformatf("v%0d_addr_a", k), 32'(bus.o_mem_addr_a), 32'(ea_addr));
      check_output($sformatf("v%0d_addr_b", k), 32'(bus.o_mem_addr_b), 32'(eb_addr));
      check_output($sformatf("v%0d_din_a", k), 32'(bus.o_mem_din_a), 32'(ea_din));
      check_output($sformatf("v%0d_din_b", k), 32'(bus.o_mem_din_b), 32'(eb_din));
      check_output($sformatf("v%0d_bank_a", k), 32'(bus.o_mem_bank_a), 32'(ea_addr[4:3]));
      check_output($sformatf("v%0d_bank_b", k), 32'(bus.o_mem_bank_b), 32'(eb_addr[4:3]));
      check_output($sformatf("v%0d_rvalid_a", k), 32'(bus.o_rvalid_a), 32'(exp_rv_a));
      check_output($sformatf("v%0d_rvalid_b", k), 32'(bus.o_rvalid_b), 32'(exp_rv_b));
      check_output($sformatf("v%0d_rdata_a", k), 32'(bus.o_rdata_a), exp_rv_a ? 32'hC3 : 32'h0);
      check_output($sformatf("v%0d_rdata_b", k), 32'(bus.o_rdata_b), exp_rv_b ? 32'h3C : 32'h0);
      check_output($sformatf("v%0d_idle", k), 32'(bus.o_idle), 32'(exp_idle));
      check_output($sformatf("v%0d_cnt", k), 32'(bus.o_conflict_cnt), 32'(exp_cnt(vecs[k].cnt)));
    end

    // reset in the middle of in-flight reads; pointer is first moved to B
    @(negedge clk);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 5'h09, 5'h09, 8'hAA, 8'hBB);
    #1;
    check_output("mr_pre_ready_a", 32'(bus.o_req_ready_a), 32'd1);
    check_output("mr_pre_ready_b", 32'(bus.o_req_ready_b), 32'd0);
    @(posedge clk);
    #1;
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'h0F, 5'h0E, 8'h00, 8'h00);
    #1;
    check_output("mr_rd_ready_a", 32'(bus.o_req_ready_a), 32'd1);
    check_output("mr_rd_ready_b", 32'(bus.o_req_ready_b), 32'd1);
    @(posedge clk);
    #1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 5'h00, 8'h00, 8'h00);
    check_output("mr_en_a", 32'(bus.o_mem_en_a), 32'd1);
    check_output("mr_en_b", 32'(bus.o_mem_en_b), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("mr_rst_en_a", 32'(bus.o_mem_en_a), 32'd0);
    check_output("mr_rst_idle", 32'(bus.o_idle), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_output($sformatf("mr_after_rvalid_a%0d", i), 32'(bus.o_rvalid_a), 32'd0);
      check_output($sformatf("mr_after_rvalid_b%0d", i), 32'(bus.o_rvalid_b), 32'd0);
      check_output($sformatf("mr_after_idle%0d", i), 32'(bus.o_idle), 32'd1);
    end
    @(negedge clk);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 5'h09, 5'h09, 8'hAA, 8'hBB);
    #1;
    check_output("mr_prio_ready_a", 32'(bus.o_req_ready_a), 32'd1);
    check_output("mr_prio_ready_b", 32'(bus.o_req_ready_b), 32'd0);
    @(posedge clk);
    #1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 5'h00, 8'h00, 8'h00);
    check_output("mr_cnt", 32'(bus.o_conflict_cnt), 32'(exp_cnt(1)));
    check_output("mr_din_a", 32'(bus.o_mem_din_a), 32'hAA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dual_port_mem_arbiter.md
Name: dual_port_mem_arbiter

Overview:
- Request scheduler in front of the dual-port multi-bank memory.
- Accepts two independent requesters (A, B) over valid/ready handshakes and resolves same-address hazards with round-robin priority.
- Issues registered enable/write/address/data to memory ports A and B.
- Tracks in-flight reads and returns read data with a valid strobe after a fixed memory read latency.

Parameters:
- WIDTH, 8, data width per port.
- ADDR_WIDTH, 5, address width (upper log2(NUM_BANK) bits select bank).
- NUM_BANK, 4, number of memory banks; used only for the bank index reported on o_mem_bank_a/b.
- READ_LATENCY, 2, cycles from memory enable (read) to valid read data on i_mem_dout_a/b; legal range 1..8.

Ports:
- i_clk  input  1  single clock for all logic.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req_valid_a / i_req_valid_b  input  1  request valid, per requester.
- o_req_ready_a / o_req_ready_b  output  1  request accepted this cycle.
- i_req_we_a / i_req_we_b  input  1  1 = write, 0 = read.
- i_req_addr_a / i_req_addr_b  input  ADDR_WIDTH  request address.
- i_req_wdata_a / i_req_wdata_b  input  WIDTH  write data.
- o_mem_en_a / o_mem_en_b  output  1  memory port enable (registered).
- o_mem_we_a / o_mem_we_b  output  1  memory port write enable (registered).
- o_mem_addr_a / o_mem_addr_b  output  ADDR_WIDTH  memory address (registered).
- o_mem_din_a / o_mem_din_b  output  WIDTH  memory write data (registered).
- o_mem_bank_a / o_mem_bank_b  output  log2(NUM_BANK)  bank index of issued address (registered).
- i_mem_dout_a / i_mem_dout_b  input  WIDTH  memory read data.
- o_rvalid_a / o_rvalid_b  output  1  read data valid.
- o_rdata_a / o_rdata_b  output  WIDTH  read data; 0 when rvalid is low.
- o_idle  output  1  no issue pending and no read in flight.
- o_conflict_cnt  output  16  conflict counter (optional feature).

Behaviour:
- Reset (async assert, sync release): all o_mem_*, o_rvalid_*, o_rdata_* = 0; o_req_ready_* = 0; priority pointer = A; read-tracking pipelines cleared; o_idle = 1; o_conflict_cnt = 0.
- Conflict: i_req_valid_a & i_req_valid_b & (addr_a == addr_b) & (we_a | we_b).
  - Two reads to the same address are NOT a conflict; both are granted.
- Grant (combinational, o_req_ready_x = grant_x):
  - Only one requester valid → grant it.
  - Both valid, no conflict → grant both.
  - Conflict → grant the priority holder only; the other sees ready = 0.
- Priority pointer:
  - Updates only on a conflict cycle: moves to the loser.
  - No change on non-conflict cycles.
- Requester rule: valid, we, addr and wdata held stable while ready is low. The arbiter does not check this.
- Issue stage:
  - Grant at cycle T → o_mem_en_x = 1 with we/addr/din/bank at T+1 (1-cycle issue latency).
  - Without a grant at T, o_mem_en_x = 0 at T+1. Address/data hold their last value, except on reset.
  - Port A traffic always maps to memory port A; B to B.
- Read tracking:
  - Per port, a READ_LATENCY-deep shift register loads (o_mem_en_x & ~o_mem_we_x).
  - o_rvalid_x = shift-register tail.
  - o_rdata_x = o_rvalid_x ? i_mem_dout_x : 0 (combinational).
  - Read accepted at T → o_rvalid_x at T+1+READ_LATENCY.
- Back-to-back: one request per port per cycle is sustained with no bubbles when conflict-free. Reads and writes may interleave freely.
- Write-then-read same address on the same port in consecutive grants: order preserved (in-order issue).
- o_idle = ~any o_mem_en & ~any bit set in either read-tracking pipeline.
- Reset mid-operation: in-flight reads dropped (no rvalid after reset release); priority returns to A.

Optional Feature:
- Macro DPM_ARB_CONFLICT_CNT_EN.
- Defined: o_conflict_cnt increments by 1 on every conflict cycle, saturating at 16'hFFFF, and clears on reset.
- Undefined: counter logic removed; o_conflict_cnt tied to 0. The port is always present.

Test Plan:
- Reset check: hold i_rst_n = 0, drive random requests → all outputs 0, o_idle = 1. Release reset → first grant appears only after release.
- Single read: A reads addr 5'h07 at T with i_mem_dout_a = 8'h5A → o_mem_en_a = 1, o_mem_we_a = 0, o_mem_addr_a = 7 at T+1; o_mem_bank_a = 0; o_rvalid_a = 1 with o_rdata_a = 8'h5A at T+3 (READ_LATENCY = 2).
- Conflict arbitration: A writes 8'h11 and B writes 8'h22, both to addr 5'h1C, held for 2 cycles →
  - Cycle 1: ready_a = 1, ready_b = 0.
  - Cycle 2: ready_b = 1.
  - o_mem_bank = 3 on both issues.
  - o_conflict_cnt = 1 when the feature is enabled.
- Repeat the conflict with priority = B → B is granted first, then A; pointer alternates across 4 consecutive conflicts.
- Same-address reads: A and B both read 5'h03 in the same cycle → both ready = 1, both o_mem_en = 1 next cycle, counter unchanged.
- Reset mid-read: issue reads on both ports, assert i_rst_n = 0 one cycle later, release → no o_rvalid pulse appears; o_idle = 1.
